csr_req_arbiter: RTL
====================

# csr_req_arbiter

Shares one accelerator CSR request/response port between `NumReq` requesters, such as two cores or a core plus a DMA configurator. It sits upstream of the CSR mux/demux and accelerator CSR managers. It grants requests round-robin and holds a grant stable under downstream back-pressure. An in-order ID FIFO routes each read response back to the requester that issued the read. Writes (`wen=1`) produce no response. Reads (`wen=0`) produce exactly one response, in issue order.

## Interface
- `NumReq`, 2: number of requesters, 2..4.
- `AddrWidth`, 8: CSR address width.
- `DataWidth`, 32: CSR data width.
- `MaxOutstanding`, 4: ID FIFO depth (outstanding reads), power of 2, ≥2.
- `IdWidth`, `$clog2(NumReq)`: derived, do not override.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_addr_i` in `[NumReq][AddrWidth]`: per-requester address.
- `req_data_i` in `[NumReq][DataWidth]`: per-requester write data.
- `req_wen_i` in `[NumReq]`: 1 = write, 0 = read.
- `req_valid_i` in `[NumReq]`: request valid.
- `req_ready_o` out `[NumReq]`: request accepted.
- `rsp_data_o` out `[NumReq][DataWidth]`: read data, broadcast to all requesters.
- `rsp_valid_o` out `[NumReq]`: response valid, one-hot to the owning requester.
- `rsp_ready_i` in `[NumReq]`: requester can take the response.
- `acc_req_addr_o`, `acc_req_data_o`, `acc_req_wen_o`, `acc_req_valid_o` out: downstream request.
- `acc_req_ready_i` in 1: downstream request ready.
- `acc_rsp_data_i` in `DataWidth`, `acc_rsp_valid_i` in 1: downstream response.
- `acc_rsp_ready_o` out 1: downstream response ready.
- `grant_cnt_o` out `[NumReq][32]`, `stall_cnt_o` out 32: present only with `CSR_ARB_PERF_CNT_EN`.

## Operation
- State: round-robin pointer `rr_q` (reset 0), lock flag `lock_q` (reset 0), locked index `lock_idx_q` (reset 0), ID FIFO (reset empty).
- Candidate set:
  - A requester is a candidate when `req_valid_i[k]=1`.
  - A read request is a candidate only while the FIFO is not full.
  - Full means `MaxOutstanding` entries. Fullness is evaluated on registered count only; a same-cycle pop does not unblock a read.
- Selection:
  - If `lock_q=1`, the selection is `lock_idx_q`.
  - Otherwise the selection is the first candidate at or after `rr_q`, scanning modulo `NumReq`.
- Downstream request:
  - Address, data, wen and valid of the selected requester are forwarded combinationally.
  - All four are '0 when there is no candidate.
  - `req_ready_o[sel]=acc_req_ready_i`; every other `req_ready_o` is 0.
- Handshake (`acc_req_valid_o & acc_req_ready_i`):
  - `rr_q` <= sel+1 mod `NumReq`.
  - `lock_q` <= 0.
  - If the request is a read, push `sel` into the FIFO.
- Stall (`acc_req_valid_o & ~acc_req_ready_i`): `lock_q` <= 1, `lock_idx_q` <= sel.
- A locked requester dropping valid is a protocol violation. While the lock is held, `acc_req_valid_o` follows `req_valid_i[lock_idx_q]` and the lock persists.
- Response routing:
  - FIFO non-empty: `rsp_valid_o[head]=acc_rsp_valid_i` and `acc_rsp_ready_o=rsp_ready_i[head]`.
  - FIFO empty: all `rsp_valid_o`=0 and `acc_rsp_ready_o`=0.
- Pop on `acc_rsp_valid_i & acc_rsp_ready_o`.
- Simultaneous push and pop: count unchanged, both pointers advance.
- FIFO pointers are `$clog2(MaxOutstanding)` bits and wrap naturally. The count is one bit wider.

## Timing
- Request path and response path are both fully combinational, with zero added latency.
- Arbitration state updates on the rising `clk_i` edge after a handshake.
- Reset values:
  - All outputs are 0 for all-zero inputs.
  - There is no registered output, except the perf counters, which reset to 0.
- Asserting `rst_ni` low mid-transaction empties the FIFO and clears the lock immediately (asynchronous). Responses still in flight downstream are then discarded: `acc_rsp_ready_o`=0 because the FIFO is empty.
- There is no combinational path from `rsp_ready_i` to `req_ready_o`.

## Configuration
- `CSR_ARB_PERF_CNT_EN` defined:
  - `grant_cnt_o[k]` increments on each handshake of requester k.
  - `stall_cnt_o` increments each cycle `acc_req_valid_o & ~acc_req_ready_i`.
  - Both are 32-bit, wrap to 0 on overflow, and reset to 0.
- Not defined: the counter ports and logic are absent and there is no other behavioural difference.

## Test plan
- Read: req0 read addr 0x03 with ack; downstream returns 0xDEADBEEF -> `rsp_valid_o=2'b01`, `rsp_data_o[0]=0xDEADBEEF`, FIFO empties.
- Round-robin: both requesters post back-to-back writes with `acc_req_ready_i=1` for 4 cycles -> grants 0,1,0,1 and no response expected.
- Lock: req1 selected, `acc_req_ready_i=0` for 3 cycles, req0 valid from cycle 1 -> downstream addr/data stay req1's and `req_ready_o[0]=0` throughout; req0 is granted the cycle after req1's handshake.
- Full FIFO (depth 4): 4 reads accepted with no responses; then 5th read -> `req_ready_o`=0. A write from the other requester is accepted that same cycle. After one response pops, the read is accepted the following cycle.
- Reset mid-op: 2 reads outstanding, pulse `rst_ni` low -> FIFO empty, `acc_rsp_ready_o=0`, `rr_q=0`; the first request after release is granted to req0 when both request.
- With `CSR_ARB_PERF_CNT_EN`: 3 grants to req0, 1 to req1, 5 stall cycles -> `grant_cnt_o={1,3}`, `stall_cnt_o=5`.

Source files
------------

// File: rtl/csr_req_arbiter.sv
// csr_req_arbiter: shares one accelerator CSR request/response port between
// NumReq requesters. Round-robin grant, grant locked under back-pressure,
// in-order ID FIFO steering read responses back to the issuing requester.
// Optional performance counters are enabled by defining CSR_ARB_PERF_CNT_EN.
module csr_req_arbiter #(
    parameter int NumReq         = 2,
    parameter int AddrWidth      = 8,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_data_i,
    input  logic [NumReq-1:0]                   req_wen_i,
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    output logic [NumReq-1:0][DataWidth-1:0]    rsp_data_o,
    output logic [NumReq-1:0]                   rsp_valid_o,
    input  logic [NumReq-1:0]                   rsp_ready_i,
    output logic [AddrWidth-1:0]                acc_req_addr_o,
    output logic [DataWidth-1:0]                acc_req_data_o,
    output logic                                acc_req_wen_o,
    output logic                                acc_req_valid_o,
    input  logic                                acc_req_ready_i,
    input  logic [DataWidth-1:0]                acc_rsp_data_i,
    input  logic                                acc_rsp_valid_i,
    output logic                                acc_rsp_ready_o
`ifdef CSR_ARB_PERF_CNT_EN
    ,
    output logic [NumReq-1:0][31:0]             grant_cnt_o,
    output logic [31:0]                         stall_cnt_o
`endif
);

    localparam int IdWidth  = $clog2(NumReq);
    localparam int PtrWidth = $clog2(MaxOutstanding);

    logic [IdWidth-1:0]  rr_q;
    logic                lock_q;
    logic [IdWidth-1:0]  lock_idx_q;
    logic [IdWidth-1:0]  sel;
    logic                any_sel;
    logic [NumReq-1:0]   cand;
    int                  scan_idx;

    logic [IdWidth-1:0]  fifo_mem [MaxOutstanding];
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [PtrWidth:0]   count_q;
    logic                fifo_full;
    logic                fifo_empty;
    logic [IdWidth-1:0]  head;
    logic                hs;
    logic                stall;
    logic                push;
    logic                pop;

    // Fullness looks at the registered count only, so a pop in the same
    // cycle never lets a blocked read through early.
    assign fifo_full  = (count_q == (PtrWidth+1)'(MaxOutstanding));
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_mem[rd_ptr_q];

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
            assign cand[gi]       = req_valid_i[gi] & (req_wen_i[gi] | ~fifo_full);
            assign rsp_data_o[gi] = acc_rsp_data_i;
        end
    endgenerate

    // Pick the locked requester, else the first candidate at or after rr_q.
    always_comb begin
        sel      = '0;
        any_sel  = 1'b0;
        scan_idx = 0;
        if (lock_q) begin
            sel     = lock_idx_q;
            any_sel = req_valid_i[lock_idx_q];
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                scan_idx = (int'(rr_q) + i) % NumReq;
                if (!any_sel && cand[IdWidth'(scan_idx)]) begin
                    any_sel = 1'b1;
                    sel     = IdWidth'(scan_idx);
                end
            end
        end
    end

    // Forward the selected request downstream; everything is zero when idle.
    always_comb begin
        req_ready_o     = '0;
        acc_req_valid_o = any_sel;
        acc_req_addr_o  = '0;
        acc_req_data_o  = '0;
        acc_req_wen_o   = 1'b0;
        if (any_sel) begin
            req_ready_o[sel] = acc_req_ready_i;
            acc_req_addr_o   = req_addr_i[sel];
            acc_req_data_o   = req_data_i[sel];
            acc_req_wen_o    = req_wen_i[sel];
        end
    end

    assign hs    = any_sel & acc_req_ready_i;
    assign stall = any_sel & ~acc_req_ready_i;
    assign push  = hs & ~acc_req_wen_o;
    assign pop   = acc_rsp_valid_i & acc_rsp_ready_o;

    // Route the downstream response to the requester at the FIFO head.
    always_comb begin
        rsp_valid_o     = '0;
        acc_rsp_ready_o = 1'b0;
        if (!fifo_empty) begin
            rsp_valid_o[head] = acc_rsp_valid_i;
            acc_rsp_ready_o   = rsp_ready_i[head];
        end
    end

    // Round-robin pointer advances on a handshake; a stall locks the grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (hs) begin
            rr_q   <= (sel == IdWidth'(NumReq - 1)) ? '0 : sel + 1'b1;
            lock_q <= 1'b0;
        end else if (stall) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
        end
    end

    // ID FIFO storage; contents need no reset because the count gates them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= sel;
        end
    end

    // ID FIFO pointers and occupancy; pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

`ifdef CSR_ARB_PERF_CNT_EN
    // Per-requester grant counters and a downstream stall-cycle counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                if (hs && (sel == IdWidth'(k))) begin
                    grant_cnt_o[k] <= grant_cnt_o[k] + 32'd1;
                end
            end
            if (stall) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
